data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that answers the pipelined CPU's load/store requests over a valid/ready handshake. It replaces the single-cycle data memory behind the MEM stage. It owns a backing line memory with a fixed, parameterised access latency. The CPU stalls its pipeline while `ready` is low.

---
 rtl/data_cache.sv | 173 +++++++++++++++++
 tb/tb_data_cache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache in front of a
// fixed-latency backing line memory, answering one load/store at a time.
module data_cache #(
   parameter int NUM_SETS    = 16,
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 4,
   parameter int MEM_LINES   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_rw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        is_hit,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int OB  = $clog2(LINE_WORDS);
   localparam int IB  = $clog2(NUM_SETS);
   localparam int TW  = 30 - OB - IB;
   localparam int LAW = 30 - OB;
   localparam int LW  = LINE_WORDS * 32;
   localparam int MAW = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
   localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITE_BACK, ALLOCATE} state_t;

   state_t state, next_state;

   logic          rw_q;
   logic [31:2]   addr_q;
   logic [31:0]   wdata_q;
   logic          miss_flag;
   logic [CW-1:0] lat_cnt;

   logic [NUM_SETS-1:0] valid_bits;
   logic [NUM_SETS-1:0] dirty_bits;
   logic [TW-1:0]       tag_arr  [NUM_SETS];
   logic [LW-1:0]       data_arr [NUM_SETS];
   logic [LW-1:0]       mem      [MEM_LINES];

   logic [OB-1:0]  off;
   logic [IB-1:0]  idx;
   logic [TW-1:0]  tag;
   logic           hit;
   logic           lat_last;
   logic [MAW-1:0] fill_line;
   logic [MAW-1:0] wb_line;
   logic           unused_byte_bits;

   // Line addresses wider than the backing memory wrap around it.
   function automatic logic [MAW-1:0] mem_line(input logic [LAW-1:0] line_addr);
      return MAW'(32'(line_addr) % 32'(MEM_LINES));
   endfunction

   assign unused_byte_bits = ^req_addr[1:0];

   assign off       = addr_q[2+OB-1:2];
   assign idx       = addr_q[2+OB+IB-1:2+OB];
   assign tag       = addr_q[31:2+OB+IB];
   assign hit       = valid_bits[idx] && (tag_arr[idx] == tag);
   assign lat_last  = (lat_cnt == CW'(MEM_LATENCY - 1));
   assign fill_line = mem_line(addr_q[31:2+OB]);
   assign wb_line   = mem_line({tag_arr[idx], idx});

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic: a miss always returns to TAG_CHECK after the fill
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (req_valid) next_state = TAG_CHECK;
         TAG_CHECK: begin
            if (hit)                                   next_state = IDLE;
            else if (valid_bits[idx] && dirty_bits[idx]) next_state = WRITE_BACK;
            else                                       next_state = ALLOCATE;
         end
         WRITE_BACK: if (lat_last) next_state = ALLOCATE;
         ALLOCATE:   if (lat_last) next_state = TAG_CHECK;
         default:    next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready      = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      case (state)
         IDLE: ready = 1'b1;
         TAG_CHECK: begin
            if (hit) begin
               resp_valid = 1'b1;
               if (!rw_q) resp_rdata = data_arr[idx][off*32 +: 32];
            end
         end
         default: ;
      endcase
   end

   // Request latch, line metadata, counters and backing memory
   always_ff @(posedge clk) begin
      if (reset) begin
         miss_flag  <= 1'b0;
         lat_cnt    <= '0;
         is_hit     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         valid_bits <= '0;
         dirty_bits <= '0;
         for (int i = 0; i < MEM_LINES; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rw_q      <= req_rw;
                  addr_q    <= req_addr[31:2];
                  wdata_q   <= req_wdata;
                  miss_flag <= 1'b0;
               end
            end
            TAG_CHECK: begin
               if (hit) begin
                  is_hit <= !miss_flag;
                  if (miss_flag) miss_count <= miss_count + 32'd1;
                  else           hit_count  <= hit_count + 32'd1;
                  if (rw_q) dirty_bits[idx] <= 1'b1;
               end else begin
                  miss_flag <= 1'b1;
                  lat_cnt   <= '0;
               end
            end
            WRITE_BACK: begin
               if (lat_last) begin
                  mem[wb_line] <= data_arr[idx];
                  lat_cnt      <= '0;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            ALLOCATE: begin
               if (lat_last) begin
                  valid_bits[idx] <= 1'b1;
                  dirty_bits[idx] <= 1'b0;
                  tag_arr[idx]    <= tag;
                  lat_cnt         <= '0;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line data is never cleared; a store to a freshly filled line lands in the following TAG_CHECK
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == TAG_CHECK && hit && rw_q)
            data_arr[idx][off*32 +: 32] <= wdata_q;
         else if (state == ALLOCATE && lat_last)
            data_arr[idx] <= mem[fill_line];
      end
   end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: two instances (MEM_LATENCY 4 and 1) compared
// against a flat-memory model plus a per-set tag tracker for response timing.
module tb_data_cache;
   localparam int MEM_LINES  = 4096;
   localparam int LINE_WORDS = 4;
   localparam int NUM_SETS   = 16;
   localparam int WORDS      = MEM_LINES * LINE_WORDS;
   localparam int TIMEOUT    = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [2];
   logic        rv      [2];
   logic        rw      [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wdata_s [2];
   logic        rdy     [2];
   logic        rsp_v   [2];
   logic [31:0] rdata_o [2];
   logic        hit_o   [2];
   logic [31:0] hc      [2];
   logic [31:0] mc      [2];

   data_cache #(.MEM_LATENCY(4)) dut_a (
      .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_rw(rw[0]),
      .req_addr(addr_s[0]), .req_wdata(wdata_s[0]), .ready(rdy[0]),
      .resp_valid(rsp_v[0]), .resp_rdata(rdata_o[0]), .is_hit(hit_o[0]),
      .hit_count(hc[0]), .miss_count(mc[0])
   );

   data_cache #(.MEM_LATENCY(1)) dut_b (
      .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_rw(rw[1]),
      .req_addr(addr_s[1]), .req_wdata(wdata_s[1]), .ready(rdy[1]),
      .resp_valid(rsp_v[1]), .resp_rdata(rdata_o[1]), .is_hit(hit_o[1]),
      .hit_count(hc[1]), .miss_count(mc[1])
   );

   logic [31:0] ref_mem  [2][WORDS];
   bit          m_valid  [2][NUM_SETS];
   bit          m_dirty  [2][NUM_SETS];
   int unsigned m_tag    [2][NUM_SETS];
   int unsigned m_hits   [2];
   int unsigned m_misses [2];

   int passed = 0;
   int total  = 0;

   function automatic void model_reset(input int w);
      for (int i = 0; i < WORDS; i++) ref_mem[w][i] = '0;
      for (int s = 0; s < NUM_SETS; s++) begin
         m_valid[w][s] = 1'b0;
         m_dirty[w][s] = 1'b0;
         m_tag[w][s]   = 0;
      end
      m_hits[w]   = 0;
      m_misses[w] = 0;
   endfunction

   // Data comes from a flat word memory; the set tracker only predicts hit/miss timing.
   function automatic void model_access(input int w, input logic op_rw, input logic [31:0] a,
                                        input logic [31:0] wd, output int lat,
                                        output logic [31:0] rd, output logic hit);
      int unsigned line_no, set, tg, word;
      int L;
      L       = (w == 0) ? 4 : 1;
      line_no = a >> 4;
      set     = line_no % NUM_SETS;
      tg      = line_no / NUM_SETS;
      word    = (a >> 2) % WORDS;
      if (m_valid[w][set] && m_tag[w][set] == tg) begin
         lat = 1;
         hit = 1'b1;
         m_hits[w]++;
      end else begin
         lat = (m_valid[w][set] && m_dirty[w][set]) ? 2 * L + 2 : L + 2;
         hit = 1'b0;
         m_misses[w]++;
         m_valid[w][set] = 1'b1;
         m_tag[w][set]   = tg;
         m_dirty[w][set] = 1'b0;
      end
      if (op_rw) begin
         ref_mem[w][word] = wd;
         m_dirty[w][set]  = 1'b1;
         rd = '0;
      end else begin
         rd = ref_mem[w][word];
      end
   endfunction

   // Issues one request from a ready-cycle negedge and returns at the negedge after the response.
   task automatic run_req(input int w, input logic op_rw, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input bit scramble,
                          output int lat, output logic [31:0] rd, output int seen);
      rv[w] = 1'b1; rw[w] = op_rw; addr_s[w] = a; wdata_s[w] = wd;
      lat = -1; rd = '0; seen = 0;
      for (int n = 1; n <= TIMEOUT && lat < 0; n++) begin
         @(negedge clk);
         if (rsp_v[w]) begin
            lat = n;
            rd  = rdata_o[w];
            seen++;
         end
         if (!hold) begin
            if (scramble) begin
               rv[w] = 1'($urandom); rw[w] = 1'($urandom);
               addr_s[w] = $urandom; wdata_s[w] = $urandom;
            end else begin
               rv[w] = 1'b0;
            end
         end
      end
      @(negedge clk);
      rv[w] = 1'b0;
      if (rsp_v[w]) seen++;
   endtask

   task automatic test_reset();
      for (int w = 0; w < 2; w++) rst[w] = 1'b1;
      repeat (2) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         total++; if (rdy[w] !== 1'b1) $display("[TB] FAIL reset ready[%0d]: got %b, expected 1", w, rdy[w]); else passed++;
         total++; if (rsp_v[w] !== 1'b0) $display("[TB] FAIL reset resp_valid[%0d]: got %b, expected 0", w, rsp_v[w]); else passed++;
         total++; if (rdata_o[w] !== 32'h0) $display("[TB] FAIL reset resp_rdata[%0d]: got %h, expected 0", w, rdata_o[w]); else passed++;
         total++; if (hit_o[w] !== 1'b0) $display("[TB] FAIL reset is_hit[%0d]: got %b, expected 0", w, hit_o[w]); else passed++;
         total++; if (hc[w] !== 32'h0) $display("[TB] FAIL reset hit_count[%0d]: got %0d, expected 0", w, hc[w]); else passed++;
         total++; if (mc[w] !== 32'h0) $display("[TB] FAIL reset miss_count[%0d]: got %0d, expected 0", w, mc[w]); else passed++;
         rst[w] = 1'b0;
         model_reset(w);
      end
   endtask

   task automatic test_cold_load_miss();
      int lat, e_lat, seen;
      logic [31:0] rd, e_rd;
      logic e_hit;
      model_access(0, 1'b0, 32'h100, 32'h0, e_lat, e_rd, e_hit);
      run_req(0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, lat, rd, seen);
      total++; if (lat !== e_lat) $display("[TB] FAIL cold latency: got %0d, expected %0d", lat, e_lat); else passed++;
      total++; if (rd !== e_rd) $display("[TB] FAIL cold rdata: got %h, expected %h", rd, e_rd); else passed++;
      total++; if (hit_o[0] !== e_hit) $display("[TB] FAIL cold is_hit: got %b, expected %b", hit_o[0], e_hit); else passed++;
      total++; if (mc[0] !== m_misses[0]) $display("[TB] FAIL cold miss_count: got %0d, expected %0d", mc[0], m_misses[0]); else passed++;
      total++; if (rdy[0] !== 1'b1) $display("[TB] FAIL cold ready after response: got %b, expected 1", rdy[0]); else passed++;
   endtask

   task automatic test_store_load_hit();
      logic        ops_rw [2] = '{1'b1, 1'b0};
      logic [31:0] ops_a  [2] = '{32'h104, 32'h104};
      logic [31:0] ops_wd [2] = '{32'hDEADBEEF, 32'h0};
      int lat, e_lat, seen;
      logic [31:0] rd, e_rd;
      logic e_hit;
      for (int i = 0; i < 2; i++) begin
         model_access(0, ops_rw[i], ops_a[i], ops_wd[i], e_lat, e_rd, e_hit);
         run_req(0, ops_rw[i], ops_a[i], ops_wd[i], 1'b0, 1'b0, lat, rd, seen);
         total++; if (lat !== e_lat) $display("[TB] FAIL hit op%0d latency: got %0d, expected %0d", i, lat, e_lat); else passed++;
         total++; if (rd !== e_rd) $display("[TB] FAIL hit op%0d rdata: got %h, expected %h", i, rd, e_rd); else passed++;
         total++; if (hit_o[0] !== e_hit) $display("[TB] FAIL hit op%0d is_hit: got %b, expected %b", i, hit_o[0], e_hit); else passed++;
         total++; if (hc[0] !== m_hits[0]) $display("[TB] FAIL hit op%0d hit_count: got %0d, expected %0d", i, hc[0], m_hits[0]); else passed++;
      end
   endtask

   task automatic test_dirty_conflict();
      logic [31:0] ops_a [2] = '{32'h204, 32'h104};
      int lat, e_lat, seen;
      logic [31:0] rd, e_rd;
      logic e_hit;
      for (int i = 0; i < 2; i++) begin
         model_access(0, 1'b0, ops_a[i], 32'h0, e_lat, e_rd, e_hit);
         run_req(0, 1'b0, ops_a[i], 32'h0, 1'b0, 1'b0, lat, rd, seen);
         total++; if (lat !== e_lat) $display("[TB] FAIL conflict op%0d latency: got %0d, expected %0d", i, lat, e_lat); else passed++;
         total++; if (rd !== e_rd) $display("[TB] FAIL conflict op%0d rdata: got %h, expected %h", i, rd, e_rd); else passed++;
         total++; if (mc[0] !== m_misses[0]) $display("[TB] FAIL conflict op%0d miss_count: got %0d, expected %0d", i, mc[0], m_misses[0]); else passed++;
      end
   endtask

   task automatic test_reset_mid_miss();
      int lat, e_lat, seen, early;
      logic [31:0] rd, e_rd;
      logic e_hit;
      early = 0;
      rv[0] = 1'b1; rw[0] = 1'b0; addr_s[0] = 32'h400; wdata_s[0] = 32'h0;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         rv[0] = 1'b0;
         if (rsp_v[0]) early++;
      end
      rst[0] = 1'b1;
      @(negedge clk);
      total++; if (early !== 0) $display("[TB] FAIL midreset early response: got %0d, expected 0", early); else passed++;
      total++; if (rdy[0] !== 1'b1) $display("[TB] FAIL midreset ready: got %b, expected 1", rdy[0]); else passed++;
      total++; if (rsp_v[0] !== 1'b0) $display("[TB] FAIL midreset resp_valid: got %b, expected 0", rsp_v[0]); else passed++;
      total++; if (hc[0] !== 32'h0) $display("[TB] FAIL midreset hit_count: got %0d, expected 0", hc[0]); else passed++;
      total++; if (mc[0] !== 32'h0) $display("[TB] FAIL midreset miss_count: got %0d, expected 0", mc[0]); else passed++;
      rst[0] = 1'b0;
      model_reset(0);
      model_access(0, 1'b0, 32'h104, 32'h0, e_lat, e_rd, e_hit);
      run_req(0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, lat, rd, seen);
      total++; if (lat !== e_lat) $display("[TB] FAIL midreset reload latency: got %0d, expected %0d", lat, e_lat); else passed++;
      total++; if (rd !== e_rd) $display("[TB] FAIL midreset reload rdata: got %h, expected %h", rd, e_rd); else passed++;
   endtask

   task automatic test_held_request();
      int lat, e_lat, seen, extra;
      logic [31:0] rd, e_rd;
      logic e_hit;
      extra = 0;
      model_access(0, 1'b0, 32'h300, 32'h0, e_lat, e_rd, e_hit);
      run_req(0, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, lat, rd, seen);
      repeat (4) begin
         @(negedge clk);
         if (rsp_v[0]) extra++;
      end
      total++; if (seen + extra !== 1) $display("[TB] FAIL held responses: got %0d, expected 1", seen + extra); else passed++;
      total++; if (lat !== e_lat) $display("[TB] FAIL held latency: got %0d, expected %0d", lat, e_lat); else passed++;
      total++; if (mc[0] !== m_misses[0]) $display("[TB] FAIL held miss_count: got %0d, expected %0d", mc[0], m_misses[0]); else passed++;
   endtask

   task automatic test_latency_one();
      logic        ops_rw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ops_a  [4] = '{32'h100, 32'h104, 32'h204, 32'h104};
      logic [31:0] ops_wd [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
      int lat, e_lat, seen;
      logic [31:0] rd, e_rd;
      logic e_hit;
      for (int i = 0; i < 4; i++) begin
         model_access(1, ops_rw[i], ops_a[i], ops_wd[i], e_lat, e_rd, e_hit);
         run_req(1, ops_rw[i], ops_a[i], ops_wd[i], 1'b0, 1'b0, lat, rd, seen);
         total++; if (lat !== e_lat) $display("[TB] FAIL lat1 op%0d latency: got %0d, expected %0d", i, lat, e_lat); else passed++;
         total++; if (rd !== e_rd) $display("[TB] FAIL lat1 op%0d rdata: got %h, expected %h", i, rd, e_rd); else passed++;
         total++; if (hit_o[1] !== e_hit) $display("[TB] FAIL lat1 op%0d is_hit: got %b, expected %b", i, hit_o[1], e_hit); else passed++;
      end
   endtask

   task automatic test_random();
      int lat, e_lat, seen;
      logic [31:0] rd, e_rd, a, wd;
      logic e_hit, op;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 150; i++) begin
            a  = 32'($urandom_range(0, 32'h7FF));
            op = 1'($urandom);
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            model_access(w, op, a, wd, e_lat, e_rd, e_hit);
            run_req(w, op, a, wd, 1'b0, 1'b1, lat, rd, seen);
            total++; if (lat !== e_lat || seen !== 1) $display("[TB] FAIL rand[%0d] #%0d latency: got %0d (%0d resp), expected %0d", w, i, lat, seen, e_lat); else passed++;
            total++; if (rd !== e_rd) $display("[TB] FAIL rand[%0d] #%0d rdata @%h: got %h, expected %h", w, i, a, rd, e_rd); else passed++;
            total++; if (hit_o[w] !== e_hit) $display("[TB] FAIL rand[%0d] #%0d is_hit: got %b, expected %b", w, i, hit_o[w], e_hit); else passed++;
         end
         total++; if (hc[w] !== m_hits[w]) $display("[TB] FAIL rand[%0d] hit_count: got %0d, expected %0d", w, hc[w], m_hits[w]); else passed++;
         total++; if (mc[w] !== m_misses[w]) $display("[TB] FAIL rand[%0d] miss_count: got %0d, expected %0d", w, mc[w], m_misses[w]); else passed++;
      end
   endtask

   initial begin
      for (int w = 0; w < 2; w++) begin
         rst[w] = 1'b1; rv[w] = 1'b0; rw[w] = 1'b0;
         addr_s[w] = '0; wdata_s[w] = '0;
      end
      test_reset();
      test_cold_load_miss();
      test_store_load_hit();
      test_dirty_conflict();
      test_reset_mid_miss();
      test_held_request();
      test_latency_one();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
